// File: rtl/lcd_timing_pkg.sv
// Shared types and constants for the LCD timing generator: power-sequence states,
// colour-bar palette and the default ALIENTEK 4.3" panel timing.
package lcd_timing_pkg;

  typedef enum logic [1:0] {
    PS_RST  = 2'd0,
    PS_WAKE = 2'd1,
    PS_RUN  = 2'd2
  } pwr_state_e;

  localparam logic [15:0] COL_WHITE   = 16'hFFFF;
  localparam logic [15:0] COL_YELLOW  = 16'hFFE0;
  localparam logic [15:0] COL_CYAN    = 16'h07FF;
  localparam logic [15:0] COL_GREEN   = 16'h07E0;
  localparam logic [15:0] COL_MAGENTA = 16'hF81F;
  localparam logic [15:0] COL_RED     = 16'hF800;
  localparam logic [15:0] COL_BLUE    = 16'h001F;
  localparam logic [15:0] COL_BLACK   = 16'h0000;

  localparam int unsigned ATK43_H_SYNC  = 41;
  localparam int unsigned ATK43_H_BACK  = 2;
  localparam int unsigned ATK43_H_DISP  = 480;
  localparam int unsigned ATK43_H_FRONT = 2;
  localparam int unsigned ATK43_V_SYNC  = 10;
  localparam int unsigned ATK43_V_BACK  = 2;
  localparam int unsigned ATK43_V_DISP  = 272;
  localparam int unsigned ATK43_V_FRONT = 2;
  localparam int unsigned ATK43_PWR_DLY = 1000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = COL_WHITE;
      3'd1:    bar_color = COL_YELLOW;
      3'd2:    bar_color = COL_CYAN;
      3'd3:    bar_color = COL_GREEN;
      3'd4:    bar_color = COL_MAGENTA;
      3'd5:    bar_color = COL_RED;
      3'd6:    bar_color = COL_BLUE;
      default: bar_color = COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Pixel-request bus between the timing generator (master) and the frame-buffer
// reader (slave); pixel_data returns one cycle after data_req.
interface lcd_timing_gen_if #(
  parameter int CW = 11
);
  logic [15:0]   pixel_data;
  logic          data_req;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          frame_start;
  logic [CW-1:0] h_res;
  logic [CW-1:0] v_res;

  modport master (
    input  pixel_data,
    output data_req, pixel_x, pixel_y, frame_start, h_res, v_res
  );

  modport slave (
    output pixel_data,
    input  data_req, pixel_x, pixel_y, frame_start, h_res, v_res
  );
endinterface

// File: rtl/lcd_pwr_seq.sv
// Panel power sequencer: hold panel in reset, release reset, then enable backlight
// and scanning; each of the first two steps lasts PWR_DLY clocks.
module lcd_pwr_seq
  import lcd_timing_pkg::*;
#(
  parameter int unsigned PWR_DLY = ATK43_PWR_DLY
) (
  input  logic clk,
  input  logic rst_n,
  output logic run,
  output logic lcd_rst,
  output logic lcd_bl
);

  localparam int DW = (PWR_DLY > 1) ? $clog2(PWR_DLY) : 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(PWR_DLY - 1);

  pwr_state_e    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PS_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PS_RST, PS_WAKE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = (state_q == PS_RST) ? PS_WAKE : PS_RUN;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      PS_RUN:  cnt_d = '0;
      default: state_d = PS_RST;
    endcase
  end

  assign run     = (state_q == PS_RUN);
  assign lcd_rst = (state_q != PS_RST);
  assign lcd_bl  = (state_q == PS_RUN);

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB-interface LCD timing generator with power sequencing and a one-cycle-latency
// pixel request bus. Define LCD_TEST_PATTERN_EN to replace pixel_data with 8 colour bars.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_SYNC  = ATK43_H_SYNC,
  parameter int unsigned H_BACK  = ATK43_H_BACK,
  parameter int unsigned H_DISP  = ATK43_H_DISP,
  parameter int unsigned H_FRONT = ATK43_H_FRONT,
  parameter int unsigned V_SYNC  = ATK43_V_SYNC,
  parameter int unsigned V_BACK  = ATK43_V_BACK,
  parameter int unsigned V_DISP  = ATK43_V_DISP,
  parameter int unsigned V_FRONT = ATK43_V_FRONT,
  parameter bit          HS_POL  = 1'b0,
  parameter bit          VS_POL  = 1'b0,
  parameter int          CW      = 11,
  parameter int unsigned PWR_DLY = ATK43_PWR_DLY
) (
  input  logic                    lcd_pclk,
  input  logic                    sys_rst,
  lcd_timing_gen_if.master        bus,
  output logic                    lcd_de,
  output logic                    lcd_hs,
  output logic                    lcd_vs,
  output logic                    lcd_clk,
  output logic [15:0]             lcd_rgb,
  output logic                    lcd_rst,
  output logic                    lcd_bl
);

  localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
  localparam logic [CW-1:0] H_ACT0   = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] H_ACT1   = CW'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CW-1:0] H_LAST   = CW'(H_SYNC + H_BACK + H_DISP + H_FRONT - 1);
  localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
  localparam logic [CW-1:0] V_ACT0   = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] V_ACT1   = CW'(V_SYNC + V_BACK + V_DISP);
  localparam logic [CW-1:0] V_LAST   = CW'(V_SYNC + V_BACK + V_DISP + V_FRONT - 1);

  logic          run;
  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic          lcd_de_q, lcd_hs_q, lcd_vs_q;
  logic          data_req;

  lcd_pwr_seq #(.PWR_DLY(PWR_DLY)) u_pwr_seq (
    .clk     (lcd_pclk),
    .rst_n   (sys_rst),
    .run     (run),
    .lcd_rst (lcd_rst),
    .lcd_bl  (lcd_bl)
  );

  // Counters are forced to the frame origin whenever the panel is not running.
  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (run) begin
      if (h_cnt_q == H_LAST) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
        v_cnt_d = v_cnt_q;
      end
    end
  end

  assign data_req = run
                 && (h_cnt_q >= H_ACT0) && (h_cnt_q < H_ACT1)
                 && (v_cnt_q >= V_ACT0) && (v_cnt_q < V_ACT1);

  always_ff @(posedge lcd_pclk or negedge sys_rst) begin
    if (!sys_rst) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      lcd_de_q <= 1'b0;
      lcd_hs_q <= !HS_POL;
      lcd_vs_q <= !VS_POL;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      lcd_de_q <= data_req;
      lcd_hs_q <= (run && (h_cnt_q < H_SYNC_C)) ? HS_POL : !HS_POL;
      lcd_vs_q <= (run && (v_cnt_q < V_SYNC_C)) ? VS_POL : !VS_POL;
    end
  end

  assign bus.data_req    = data_req;
  assign bus.pixel_x     = data_req ? (h_cnt_q - H_ACT0) : '0;
  assign bus.pixel_y     = data_req ? (v_cnt_q - V_ACT0) : '0;
  assign bus.frame_start = run && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign bus.h_res       = CW'(H_DISP);
  assign bus.v_res       = CW'(V_DISP);

  assign lcd_de  = lcd_de_q;
  assign lcd_hs  = lcd_hs_q;
  assign lcd_vs  = lcd_vs_q;
  assign lcd_clk = lcd_pclk;

`ifdef LCD_TEST_PATTERN_EN
  // The bar shown is chosen by the column requested on the previous cycle.
  localparam logic [CW-1:0] BAR_W = (H_DISP >= 8) ? CW'(H_DISP / 8) : CW'(1);

  logic [CW-1:0] pat_x_q;
  logic [CW-1:0] bar_q;
  logic [2:0]    bar_idx;

  always_ff @(posedge lcd_pclk or negedge sys_rst) begin
    if (!sys_rst) pat_x_q <= '0;
    else          pat_x_q <= bus.pixel_x;
  end

  assign bar_q   = pat_x_q / BAR_W;
  assign bar_idx = (bar_q > CW'(7)) ? 3'd7 : bar_q[2:0];
  assign lcd_rgb = lcd_de_q ? bar_color(bar_idx) : 16'h0000;
`else
  assign lcd_rgb = lcd_de_q ? bus.pixel_data : 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen: a cycle-indexed reference model derived from
// the frame geometry, random resets and random pixel data.
module tb_lcd_timing_gen;

  localparam int HT = 12, VT = 7, PWR = 4;
  localparam int HA0 = 3, HA1 = 11, VA0 = 2, VA1 = 6;

  logic        lcd_pclk = 1'b0;
  logic        sys_rst;
  logic        lcd_de, lcd_hs, lcd_vs, lcd_clk, lcd_rst, lcd_bl;
  logic [15:0] lcd_rgb;
  logic [15:0] pd;
  logic        a5_mode;
  int          t;
  int          n_chk = 0, n_err = 0;
  int          req_cnt, hs_cnt, vs_cnt;

  lcd_timing_gen_if #(.CW(11)) bus ();

  lcd_timing_gen #(
    .H_SYNC(2), .H_BACK(1), .H_DISP(8), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(11), .PWR_DLY(PWR)
  ) dut (
    .lcd_pclk (lcd_pclk),
    .sys_rst  (sys_rst),
    .bus      (bus),
    .lcd_de   (lcd_de),
    .lcd_hs   (lcd_hs),
    .lcd_vs   (lcd_vs),
    .lcd_clk  (lcd_clk),
    .lcd_rgb  (lcd_rgb),
    .lcd_rst  (lcd_rst),
    .lcd_bl   (lcd_bl)
  );

  always #5 lcd_pclk = ~lcd_pclk;
  assign bus.pixel_data = pd;

  // Clock edges seen since reset release; the whole model is a function of this.
  always @(posedge lcd_pclk or negedge sys_rst) begin
    if (!sys_rst) t <= 0;
    else          t <= t + 1;
  end

  typedef struct packed {
    logic        rst_o, bl, req, fs, hsy, vsy;
    logic [10:0] px, py;
  } m_t;

  function automatic m_t comb_at(input int tt);
    m_t m;
    int k, h, v;
    m = '0;
    m.rst_o = (tt >= PWR);
    m.bl    = (tt >= 2 * PWR);
    if (tt >= 2 * PWR) begin
      k = tt - 2 * PWR;
      h = k % HT;
      v = (k / HT) % VT;
      m.req = (h >= HA0) && (h < HA1) && (v >= VA0) && (v < VA1);
      m.px  = m.req ? 11'(h - HA0) : 11'd0;
      m.py  = m.req ? 11'(v - VA0) : 11'd0;
      m.fs  = (h == 0) && (v == 0);
      m.hsy = (h < 2);
      m.vsy = (v < 1);
    end
    return m;
  endfunction

  function automatic logic [15:0] bar_of(input logic [10:0] x);
    logic [15:0] pal [8];
    pal = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    return (x > 11'd7) ? pal[7] : pal[x[2:0]];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0d rst=%0b)", name, act, exp, t, sys_rst);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_lcd_rst"}, lcd_rst, 0);
    check({tag, "_lcd_bl"},  lcd_bl, 0);
    check({tag, "_de"},      lcd_de, 0);
    check({tag, "_req"},     bus.data_req, 0);
    check({tag, "_fs"},      bus.frame_start, 0);
    check({tag, "_hs"},      lcd_hs, 0);
    check({tag, "_vs"},      lcd_vs, 1);
    check({tag, "_rgb"},     lcd_rgb, 0);
    check({tag, "_px"},      bus.pixel_x, 0);
    check({tag, "_py"},      bus.pixel_y, 0);
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge lcd_pclk) begin
    m_t          m, p;
    logic        de_e, hs_e, vs_e;
    logic [15:0] rgb_e;
    logic        req_now;
    req_now = 1'b0;
    check("h_res", bus.h_res, 8);
    check("v_res", bus.v_res, 4);
    check("lcd_clk_lo", lcd_clk, 0);
    if (!sys_rst) begin
      check_reset_values("rst");
      req_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    end else begin
      m = comb_at(t);
      if (t == 0) begin
        p = '0; de_e = 1'b0; hs_e = 1'b0; vs_e = 1'b1;
      end else begin
        p = comb_at(t - 1);
        de_e = p.req; hs_e = p.hsy; vs_e = !p.vsy;
      end
`ifdef LCD_TEST_PATTERN_EN
      rgb_e = de_e ? bar_of(p.px) : 16'h0000;
      if (de_e && p.px == 11'd0) check("pattern_x0", lcd_rgb, 16'hFFFF);
      if (de_e && p.px == 11'd5) check("pattern_x5", lcd_rgb, 16'hF800);
`else
      rgb_e = de_e ? pd : 16'h0000;
      if (de_e && a5_mode) check("a5_rgb", lcd_rgb, 16'hA5A5);
`endif
      check("lcd_rst", lcd_rst, m.rst_o);
      check("lcd_bl", lcd_bl, m.bl);
      check("data_req", bus.data_req, m.req);
      check("pixel_x", bus.pixel_x, m.px);
      check("pixel_y", bus.pixel_y, m.py);
      check("frame_start", bus.frame_start, m.fs);
      check("lcd_de", lcd_de, de_e);
      check("lcd_hs", lcd_hs, hs_e);
      check("lcd_vs", lcd_vs, vs_e);
      check("lcd_rgb", lcd_rgb, rgb_e);
      req_now = m.req;

      // Hand-derived anchors for the 12x7 frame with PWR_DLY=4.
      if (t == 3)  check("lit_rst_t3", lcd_rst, 0);
      if (t == 4)  check("lit_rst_t4", lcd_rst, 1);
      if (t == 7)  check("lit_bl_t7", lcd_bl, 0);
      if (t == 8)  check("lit_fs_bl_t8", {bus.frame_start, lcd_bl}, 2'b11);
      if (t == 34) check("lit_req_t34", bus.data_req, 0);
      if (t == 35) check("lit_first_req", {bus.data_req, bus.pixel_x, bus.pixel_y}, {1'b1, 11'd0, 11'd0});
      if (t == 78) check("lit_last_req", {bus.data_req, bus.pixel_x, bus.pixel_y}, {1'b1, 11'd7, 11'd3});
      if (t == 79) check("lit_req_t79", bus.data_req, 0);

      if (t == 176) check("req_per_frame", req_cnt, 32);
      if (t == 57)  check("hs_high_per_line", hs_cnt, 2);
      if (t == 177) check("vs_low_per_frame", vs_cnt, 12);
      if (t >= 92 && t < 176 && bus.data_req) req_cnt++;
      if (t >= 45 && t < 57 && lcd_hs)        hs_cnt++;
      if (t >= 93 && t < 177 && !lcd_vs)      vs_cnt++;
    end
`ifdef LCD_TEST_PATTERN_EN
    pd = 16'h0000;
`else
    pd = (a5_mode && req_now) ? 16'hA5A5 : 16'($urandom);
`endif
  end

  task automatic step_to_mid_high();
    @(posedge lcd_pclk);
    #2;
  endtask

  initial begin
    bit found;
    pd      = 16'h0000;
    a5_mode = 1'b0;
    sys_rst = 1'b1;
    #1 sys_rst = 1'b0;
    repeat (3) @(negedge lcd_pclk);
    @(posedge lcd_pclk);
    #1 check("lcd_clk_hi", lcd_clk, 1);
    #1 sys_rst = 1'b1;
    repeat (260) @(posedge lcd_pclk);

    // Abort mid-frame at h_cnt=5, v_cnt=3 (t = 8 + 3*12 + 5).
    a5_mode = 1'b1;
    step_to_mid_high();
    sys_rst = 1'b0;
    repeat (2) step_to_mid_high();
    sys_rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step_to_mid_high();
      if (t == 49) begin found = 1'b1; break; end
    end
    check("reach_h5_v3", found, 1);
    sys_rst = 1'b0;
    #1 check_reset_values("midframe");
    repeat (2) step_to_mid_high();
    sys_rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge lcd_pclk);
      #1;
      if (bus.frame_start) begin found = 1'b1; break; end
    end
    check("replay_fs_found", found, 1);
    check("replay_fs_t", t, 8);
    check("replay_fs_bl", lcd_bl, 1);

    for (int r = 0; r < 6; r++) begin
      a5_mode = r[0];
      repeat ($urandom_range(20, 250)) @(posedge lcd_pclk);
      step_to_mid_high();
      sys_rst = 1'b0;
      repeat ($urandom_range(1, 3)) step_to_mid_high();
      sys_rst = 1'b1;
    end
    repeat (200) @(posedge lcd_pclk);
    @(negedge lcd_pclk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_SYNC, 41: line sync width in pclk.
- H_BACK, 2: back porch.
- H_DISP, 480: active pixels.
- H_FRONT, 2: front porch.
- V_SYNC, 10; V_BACK, 2; V_DISP, 272; V_FRONT, 2: same fields, in lines.
- HS_POL, 0; VS_POL, 0: sync active level.
- CW, 11: counter and coordinate width.
- PWR_DLY, 1000: power-sequence step length, in pclk.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- lcd_pclk, in, 1: the one clock.
- sys_rst, in, 1: reset, asynchronous, active-low.
- pixel_data, in, 16: RGB565 pixel.
- data_req, out, 1: pixel request.
- pixel_x, out, CW: requested column.
- pixel_y, out, CW: requested row.
- frame_start, out, 1: frame start pulse.
- h_res, out, CW: equals H_DISP.
- v_res, out, CW: equals V_DISP.
- lcd_de, lcd_hs, lcd_vs, out, 1 each: panel timing.
- lcd_clk, out, 1: panel clock.
- lcd_rgb, out, 16: panel pixel data.
- lcd_rst, out, 1: panel reset.
- lcd_bl, out, 1: backlight.
REQ-003 Clock and reset SHALL be one clock, lcd_pclk; reset sys_rst is asynchronous and active-low.

Function
REQ-004 H_TOTAL SHALL be H_SYNC+H_BACK+H_DISP+H_FRONT and V_TOTAL the vertical equivalent; each total SHALL fit in CW bits, with H_DISP≥1 and V_DISP≥1.
REQ-005 The power FSM SHALL have states:
- PS_RST: lcd_rst=0, lcd_bl=0.
- PS_WAKE: lcd_rst=1, lcd_bl=0.
- PS_RUN: lcd_rst=1, lcd_bl=1.
REQ-006 Each of PS_RST and PS_WAKE SHALL last exactly PWR_DLY cycles (PWR_DLY≥1); PS_RUN SHALL be terminal until reset.
REQ-007 h_cnt and v_cnt SHALL be held at 0 outside PS_RUN.
REQ-008 In PS_RUN, h_cnt SHALL step 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL advance only when h_cnt=H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0.
REQ-009 data_req SHALL be combinational and high iff PS_RUN and h_cnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
REQ-010 pixel_x and pixel_y SHALL be 0-based active coordinates while data_req=1, and 0 otherwise.
REQ-011 lcd_de SHALL be data_req delayed by exactly one cycle, registered.
REQ-012 The requester SHALL present pixel_data one cycle after data_req, i.e. a one-cycle read latency.
REQ-013 lcd_rgb SHALL be pixel_data when lcd_de=1, else 16'h0000.
REQ-014 lcd_hs SHALL be registered, at level HS_POL when the previous-cycle h_cnt<H_SYNC in PS_RUN, else at level !HS_POL; lcd_vs SHALL follow the same rule using v_cnt, V_SYNC and VS_POL.
REQ-015 frame_start SHALL be a one-cycle combinational pulse when PS_RUN and h_cnt=0 and v_cnt=0.
REQ-016 lcd_clk SHALL equal lcd_pclk.
REQ-017 h_res and v_res SHALL be constants.

Reset
REQ-018 While sys_rst=0, outputs SHALL be:
- FSM in PS_RST, counters 0.
- lcd_rst=0, lcd_bl=0, lcd_de=0, data_req=0, frame_start=0.
- lcd_hs=!HS_POL, lcd_vs=!VS_POL, lcd_rgb=0.
REQ-019 A reset asserted mid-frame or mid-sequence SHALL abort it immediately; the full power sequence SHALL replay after release.

Configuration
REQ-020 With LCD_TEST_PATTERN_EN defined, lcd_rgb during lcd_de SHALL be an internal pattern of 8 vertical bars, each H_DISP/8 wide (last bar absorbs the remainder), coloured in order 16'hFFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. pixel_data SHALL be ignored, and data_req/pixel_x/pixel_y SHALL be unchanged.
REQ-021 Without LCD_TEST_PATTERN_EN, no pattern logic SHALL exist.

Structure
REQ-022 A package lcd_timing_pkg SHALL hold the power-state enumeration, the bar colour constants and the default ALIENTEK 4.3" timing constants.
REQ-023 The power FSM SHALL be the sub-module lcd_pwr_seq, with outputs run, lcd_rst and lcd_bl.

Verification
All scenarios use H_SYNC=2, H_BACK=1, H_DISP=8, H_FRONT=1 (H_TOTAL=12) and V_SYNC=1, V_BACK=1, V_DISP=4, V_FRONT=1 (V_TOTAL=7), with PWR_DLY=4.
REQ-024 Power-up: release reset → lcd_rst rises 4 cycles after release, lcd_bl 8 cycles after release; first frame_start coincides with lcd_bl=1.
REQ-025 Active window: first data_req at h_cnt=3, v_cnt=2 with pixel_x=0, pixel_y=0; last at pixel_x=7, pixel_y=3; exactly 32 data_req per 84-cycle frame.
REQ-026 Latency: drive pixel_data=16'hA5A5 one cycle after each data_req → lcd_de high in that cycle and lcd_rgb=16'hA5A5; lcd_rgb=0 whenever lcd_de=0.
REQ-027 Sync: HS_POL=1 → lcd_hs high for exactly 2 of every 12 cycles; VS_POL=0 → lcd_vs low for exactly 12 cycles per frame.
REQ-028 Reset mid-frame: assert sys_rst at h_cnt=5, v_cnt=3 → all outputs reach reset values immediately; after release the power sequence replays before the next frame_start.
REQ-029 LCD_TEST_PATTERN_EN: with pixel_data held at 0 → lcd_rgb=16'hFFFF at pixel_x=0 and 16'hF800 at pixel_x=5.
